scale_pipe: RTL and testbench

- Parametrised successor to the single-lane requantiser.
- Converts DN lanes of signed DW-bit accumulator results to signed OW-bit activations. Per lane: multiply by a per-lane unsigned scale, round-shift by n, add an output zero-point, optional ReLU, then saturate.
- Adds valid/ready backpressure, round-half-up, zero-point and per-lane saturation flags.
- Sits between the MAC array accumulator drain and the activation write-back buffer.

---
 rtl/scale_pkg.sv | 45 ++++
 rtl/scale_lane.sv | 59 +++++
 rtl/scale_pipe.sv | 81 ++++++++
 tb/tb_scale_pipe.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/scale_pkg.sv
// rtl/scale_pkg.sv - shared widths and arithmetic helpers for the requantiser pipeline
package scale_pkg;

  localparam int DW_DEF = 22;
  localparam int DN_DEF = 4;
  localparam int MW_DEF = 9;
  localparam int SW_DEF = 5;
  localparam int OW_DEF = 8;

  // Helpers work on a generous fixed width so any lane configuration fits.
  localparam int WIDE = 64;
  typedef logic signed [WIDE-1:0] wide_t;

  typedef struct packed {
    wide_t value;
    logic  sat;
  } clip_t;

  // Round half up (ties toward +inf), then arithmetic shift.
  function automatic wide_t round_shift(input wide_t p, input int unsigned n);
    wide_t bias;
    if (n == 0) return p;
    bias = wide_t'(1) <<< (n - 1);
    return (p + bias) >>> n;
  endfunction

  function automatic clip_t sat_clip(input wide_t v, input int unsigned ow);
    wide_t hi;
    wide_t lo;
    clip_t c;
    hi = (wide_t'(1) <<< (ow - 1)) - wide_t'(1);
    lo = -(wide_t'(1) <<< (ow - 1));
    c.value = v;
    c.sat   = 1'b0;
    if (v > hi) begin
      c.value = hi;
      c.sat   = 1'b1;
    end else if (v < lo) begin
      c.value = lo;
      c.sat   = 1'b1;
    end
    return c;
  endfunction

endpackage

// File: rtl/scale_lane.sv
// rtl/scale_lane.sv - one lane: multiply, round-shift, offset/ReLU/saturate
module scale_lane
  import scale_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int MW = MW_DEF,
  parameter int SW = SW_DEF,
  parameter int OW = OW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [DW-1:0] a,
  input  logic [MW-1:0] m,
  input  logic [SW-1:0] n1,
  input  logic [OW-1:0] zp2,
  input  logic          relu2,
  output logic [OW-1:0] y,
  output logic          sat
);

  localparam int PW = DW + MW + 1;

  logic signed [PW-1:0] a_x;
  logic signed [PW-1:0] m_x;
  logic signed [PW-1:0] p_q;
  logic signed [PW-1:0] r_q;
  logic signed [PW-1:0] r_d;
  wide_t                r_w;
  wide_t                v_w;
  clip_t                c;

  // Scale is unsigned: a zero MSB keeps it positive in the signed multiply.
  assign a_x = PW'($signed(a));
  assign m_x = PW'({1'b0, m});

  always_comb begin
    r_w = round_shift(wide_t'(p_q), 32'(n1));
    r_d = r_w[PW-1:0];
    v_w = wide_t'(r_q) + wide_t'($signed(zp2));
    if (relu2 && (v_w < 0)) v_w = '0;
    c = sat_clip(v_w, OW);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      p_q <= '0;
      r_q <= '0;
      y   <= '0;
      sat <= 1'b0;
    end else if (en) begin
      p_q <= a_x * m_x;
      r_q <= r_d;
      y   <= c.value[OW-1:0];
      sat <= c.sat;
    end
  end

endmodule

// File: rtl/scale_pipe.sv
// rtl/scale_pipe.sv - DN-lane requantiser with valid/ready and a whole-pipe stall
module scale_pipe
  import scale_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int DN = DN_DEF,
  parameter int MW = MW_DEF,
  parameter int SW = SW_DEF,
  parameter int OW = OW_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             m_valid,
  output logic             m_ready,
  input  logic [DN*DW-1:0] m_data1,
  input  logic [DN*MW-1:0] m_data2,
  input  logic [SW-1:0]    n,
  input  logic [OW-1:0]    zp,
  input  logic             relu_en,
  output logic             s_valid,
  input  logic             s_ready,
  output logic [DN*OW-1:0] s_data,
  output logic [DN-1:0]    s_sat
);

  logic          en;
  logic          v1;
  logic          v2;
  logic [SW-1:0] n1;
  logic [OW-1:0] zp1;
  logic [OW-1:0] zp2;
  logic          relu1;
  logic          relu2;

  assign en      = !s_valid || s_ready;
  assign m_ready = en;

  // Mode travels with its beat so changes never touch beats in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1      <= 1'b0;
      v2      <= 1'b0;
      s_valid <= 1'b0;
      n1      <= '0;
      zp1     <= '0;
      zp2     <= '0;
      relu1   <= 1'b0;
      relu2   <= 1'b0;
    end else if (en) begin
      v1      <= m_valid;
      v2      <= v1;
      s_valid <= v2;
      n1      <= n;
      zp1     <= zp;
      zp2     <= zp1;
      relu1   <= relu_en;
      relu2   <= relu1;
    end
  end

  for (genvar i = 0; i < DN; i++) begin : g_lane
    scale_lane #(
      .DW(DW),
      .MW(MW),
      .SW(SW),
      .OW(OW)
    ) u_lane (
      .clk  (clk),
      .rst  (rst),
      .en   (en),
      .a    (m_data1[i*DW +: DW]),
      .m    (m_data2[i*MW +: MW]),
      .n1   (n1),
      .zp2  (zp2),
      .relu2(relu2),
      .y    (s_data[i*OW +: OW]),
      .sat  (s_sat[i])
    );
  end

endmodule

// File: tb/tb_scale_pipe.sv
// tb/tb_scale_pipe.sv - scoreboard bench for scale_pipe
module tb_scale_pipe;

  localparam int DW = 22;
  localparam int DN = 4;
  localparam int MW = 9;
  localparam int SW = 5;
  localparam int OW = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             m_valid;
  logic             m_ready;
  logic [DN*DW-1:0] m_data1;
  logic [DN*MW-1:0] m_data2;
  logic [SW-1:0]    n;
  logic [OW-1:0]    zp;
  logic             relu_en;
  logic             s_valid;
  logic             s_ready;
  logic [DN*OW-1:0] s_data;
  logic [DN-1:0]    s_sat;

  typedef struct {
    logic [DN*OW-1:0] data;
    logic [DN-1:0]    sat;
    int               acc;
    bit               lat;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   lat_on = 1'b0;
  bit   bp_on = 1'b0;
  bit   bp_pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
  int   bp_idx = 0;

  scale_pipe #(.DW(DW), .DN(DN), .MW(MW), .SW(SW), .OW(OW)) dut (
    .clk    (clk),
    .rst    (rst),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .m_data1(m_data1),
    .m_data2(m_data2),
    .n      (n),
    .zp     (zp),
    .relu_en(relu_en),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .s_data (s_data),
    .s_sat  (s_sat)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    s_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (bp_on) begin
        s_ready = bp_pat[bp_idx];
        bp_idx  = (bp_idx + 1) % 4;
      end
    end
  end

  // Monitor: pops on every output handshake, checks stall stability.
  initial begin
    bit               prev_stall = 1'b0;
    logic [DN*OW-1:0] prev_data;
    logic [DN-1:0]    prev_sat;
    exp_t             e;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        prev_stall = 1'b0;
        continue;
      end
      if (prev_stall) begin
        checks++;
        if (s_data !== prev_data || s_sat !== prev_sat) begin
          errors++;
          $display("FAIL stall_stable got=%h/%b held=%h/%b", s_data, s_sat, prev_data, prev_sat);
        end
      end
      if (s_valid && !s_ready) begin
        checks++;
        if (m_ready !== 1'b0) begin
          errors++;
          $display("FAIL stall_m_ready got=%b exp=0", m_ready);
        end
      end
      prev_stall = s_valid && !s_ready;
      prev_data  = s_data;
      prev_sat   = s_sat;
      if (s_valid && s_ready) begin
        checks++;
        if (sbq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_beat got=%h/%b exp=none", s_data, s_sat);
        end else begin
          e = sbq.pop_front();
          if (s_data !== e.data) begin
            errors++;
            $display("FAIL s_data got=%h exp=%h", s_data, e.data);
          end
          checks++;
          if (s_sat !== e.sat) begin
            errors++;
            $display("FAIL s_sat got=%b exp=%b", s_sat, e.sat);
          end
          if (e.lat) begin
            checks++;
            if (cyc != e.acc + 3) begin
              errors++;
              $display("FAIL latency got=%0d exp=%0d", cyc - e.acc, 3);
            end
          end
        end
      end
    end
  end

  task automatic send_vec(input logic [DN*DW-1:0] d1, input logic [DN*MW-1:0] d2,
                          input int nn, input int z, input bit r,
                          input logic [DN*OW-1:0] ey, input logic [DN-1:0] es);
    exp_t e;
    bit   acc = 1'b0;
    int   guard = 0;
    @(negedge clk);
    m_valid = 1'b1;
    m_data1 = d1;
    m_data2 = d2;
    n       = nn[SW-1:0];
    zp      = z[OW-1:0];
    relu_en = r;
    while (!acc) begin
      #1;
      acc   = m_ready;
      e.data = ey;
      e.sat  = es;
      e.acc  = cyc;
      e.lat  = lat_on;
      @(posedge clk);
      if (acc) begin
        sbq.push_back(e);
      end else begin
        guard++;
        if (guard > 100) begin
          checks++;
          errors++;
          $display("FAIL accept_timeout got=%0d exp<=100", guard);
          break;
        end
        @(negedge clk);
      end
    end
  endtask

  task automatic send1(input int a, input int m, input int nn, input int z,
                       input bit r, input int y, input bit s);
    logic [DN*DW-1:0] d1;
    logic [DN*MW-1:0] d2;
    logic [DN*OW-1:0] ey;
    logic [DN-1:0]    es;
    for (int i = 0; i < DN; i++) begin
      d1[i*DW +: DW] = a[DW-1:0];
      d2[i*MW +: MW] = m[MW-1:0];
      ey[i*OW +: OW] = y[OW-1:0];
      es[i]          = s;
    end
    send_vec(d1, d2, nn, z, r, ey, es);
  endtask

  task automatic idle(input int k);
    @(negedge clk);
    m_valid = 1'b0;
    repeat (k) @(negedge clk);
  endtask

  task automatic drain();
    int t = 0;
    while (sbq.size() != 0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (sbq.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout got=%0d exp=0 pending", sbq.size());
    end
  endtask

  task automatic check_idle(input string tag);
    checks++;
    if (s_valid !== 1'b0 || s_data !== '0 || s_sat !== '0 || m_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s got v=%b d=%h s=%b r=%b exp v=0 d=0 s=0 r=1", tag, s_valid, s_data, s_sat, m_ready);
    end
  endtask

  int lane_d[8] = '{100, 600, 1000, 3000, 4500, 8000, 58824, -1000};
  int lane_y[8] = '{0, 1, 2, 5, 8, 14, 100, -2};

  initial begin
    logic [DN*DW-1:0] d1;
    logic [DN*MW-1:0] d2;
    rst = 1'b1;
    m_valid = 1'b0;
    m_data1 = '0;
    m_data2 = '0;
    n = '0;
    zp = '0;
    relu_en = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #3;
    check_idle("reset_state");

    lat_on = 1'b1;
    for (int i = 0; i < 8; i++) send1(lane_d[i], 222, 17, 0, 1'b0, lane_y[i], 1'b0);
    send1(-3000, 222, 17, 0, 1'b0, -5, 1'b0);
    send1(-4500, 222, 17, 0, 1'b0, -8, 1'b0);
    send1(-58824, 222, 17, 0, 1'b0, -100, 1'b0);
    send1(-1500, 222, 17, 0, 1'b1, 0, 1'b0);
    send1(-10000, 222, 17, 0, 1'b1, 0, 1'b0);
    send1(58824, 222, 17, 0, 1'b1, 100, 1'b0);
    send1(-58824, 222, 17, 0, 1'b1, 0, 1'b0);
    send1(200000, 222, 17, 0, 1'b0, 127, 1'b1);
    send1(-200000, 222, 17, 0, 1'b0, -128, 1'b1);
    send1(-200000, 222, 17, 0, 1'b1, 0, 1'b0);
    send1(58824, 222, 17, 10, 1'b0, 110, 1'b0);
    send1(58824, 222, 17, 30, 1'b0, 127, 1'b1);
    send1(1, 1, 0, 0, 1'b0, 1, 1'b0);
    send1(127, 1, 0, 0, 1'b0, 127, 1'b0);
    send1(128, 1, 0, 0, 1'b0, 127, 1'b1);
    send1(-128, 1, 0, 0, 1'b0, -128, 1'b0);
    send1(-129, 1, 0, 0, 1'b0, -128, 1'b1);
    send1(3, 1, 1, 0, 1'b0, 2, 1'b0);
    send1(-3, 1, 1, 0, 1'b0, -1, 1'b0);

    // Per-lane scales, then n changes on the very next beat.
    for (int i = 0; i < DN; i++) d1[i*DW +: DW] = 22'd58824;
    d2 = {9'd511, 9'd0, 9'd444, 9'd222};
    send_vec(d1, d2, 17, 0, 1'b0, {8'd127, 8'd0, 8'd127, 8'd100}, 4'b1010);
    send_vec(d1, d2, 16, 0, 1'b0, {8'd127, 8'd0, 8'd127, 8'd127}, 4'b1011);
    idle(6);
    drain();

    lat_on = 1'b0;
    bp_idx = 0;
    bp_on  = 1'b1;
    for (int k = 1; k <= 8; k++) send1(13 * k, 1, 0, 0, 1'b0, 13 * k, 1'b0);
    idle(2);
    drain();
    bp_on = 1'b0;
    @(negedge clk);
    s_ready = 1'b0;

    send1(58824, 222, 17, 0, 1'b0, 100, 1'b0);
    send1(600, 222, 17, 0, 1'b0, 1, 1'b0);
    send1(1000, 222, 17, 0, 1'b0, 2, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    m_valid = 1'b0;
    sbq.delete();
    @(negedge clk);
    rst = 1'b0;
    s_ready = 1'b1;
    #3;
    check_idle("mid_reset");
    repeat (10) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=timeout exp=finish");
    $fatal(1);
  end

endmodule
